// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg.sv - shared action encodings, defaults and priority helper for program_sequencer
// Contents:
//   act_e          - one-hot-free action select: STEP, LD, BR, CALL, RET
//   DEF_ADDR_W     - default fetch address width
//   DEF_RESET_ADDR - default fetch address after reset
//   select_action  - fixed-priority strobe decode (Ret > Call > Ld > Br > step)
package program_sequencer_pkg;

    localparam int          DEF_ADDR_W     = 16;
    localparam logic [15:0] DEF_RESET_ADDR = 16'h0000;

    typedef enum logic [2:0] {
        ACT_STEP = 3'd0,
        ACT_LD   = 3'd1,
        ACT_BR   = 3'd2,
        ACT_CALL = 3'd3,
        ACT_RET  = 3'd4
    } act_e;

    // Lower-priority strobes are simply dropped, never queued.
    function automatic act_e select_action(input logic ret, input logic call,
                                           input logic ld, input logic br);
        if (ret)  return ACT_RET;
        if (call) return ACT_CALL;
        if (ld)   return ACT_LD;
        if (br)   return ACT_BR;
        return ACT_STEP;
    endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// program_sequencer_return_stack.sv - LIFO return-address stack with depth/full/empty status
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset, empties the stack
//   push       in   push push_data (ignored when full)
//   pop        in   drop top entry (ignored when empty)
//   push_data  in   W-bit address to push
//   top        out  current top entry ('0 when empty)
//   depth      out  number of valid entries (registered)
//   full       out  depth == DEPTH
//   empty      out  depth == 0
module program_sequencer_return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] depth_q;
    logic [CNT_W-1:0] depth_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (depth_q == CNT_W'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Entry i holds the (i+1)-th pushed value; depth_q doubles as the write slot.
    always_comb begin
        top     = '0;
        depth_d = depth_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (CNT_W'(i + 1) == depth_q) begin
                top = mem_q[i];
            end
            if (do_push && (CNT_W'(i) == depth_q)) begin
                mem_d[i] = push_data;
            end
        end
        if (do_push) begin
            depth_d = depth_q + CNT_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Contents need no reset: entries above depth are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer.sv - instruction fetch address generator with step/load/branch/call/return
// Ports:
//   clk         in   clock
//   Pc_Rst      in   synchronous active-high reset
//   Pc_En       in   advance enable, 0 holds all state
//   Pc_Ld       in   absolute jump to Pc_addr_in
//   Pc_Br       in   relative branch by signed Pc_Off
//   Pc_Call     in   push return address, jump to Pc_addr_in
//   Pc_Ret      in   pop return address into inst_addr
//   Pc_addr_in  in   jump/call target
//   Pc_Off      in   two's complement branch offset
//   inst_addr   out  registered fetch address
//   Stk_Depth   out  return-stack occupancy
//   Stk_Full    out  stack full
//   Stk_Empty   out  stack empty
//   Stk_Ovf     out  sticky: call while full
//   Stk_Unf     out  sticky: return while empty
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                OFF_W      = 8,
    parameter int                STEP       = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
    parameter int                STK_DEPTH  = 4,
    parameter int                STK_CNT_W  = 3
) (
    input  logic                 clk,
    input  logic                 Pc_Rst,
    input  logic                 Pc_En,
    input  logic                 Pc_Ld,
    input  logic                 Pc_Br,
    input  logic                 Pc_Call,
    input  logic                 Pc_Ret,
    input  logic [ADDR_W-1:0]    Pc_addr_in,
    input  logic [OFF_W-1:0]     Pc_Off,
    output logic [ADDR_W-1:0]    inst_addr,
    output logic [STK_CNT_W-1:0] Stk_Depth,
    output logic                 Stk_Full,
    output logic                 Stk_Empty,
    output logic                 Stk_Ovf,
    output logic                 Stk_Unf
);

    logic [ADDR_W-1:0] inst_addr_q;
    logic [ADDR_W-1:0] inst_addr_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] br_addr;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_push;
    logic              stk_pop;
    act_e              act;

    // Modulo 2**ADDR_W wrap falls out of the fixed-width adders.
    assign seq_addr = inst_addr_q + ADDR_W'(STEP);
    assign br_addr  = inst_addr_q + {{(ADDR_W - OFF_W){Pc_Off[OFF_W-1]}}, Pc_Off};
    assign act      = select_action(Pc_Ret, Pc_Call, Pc_Ld, Pc_Br);

    always_comb begin
        inst_addr_d = inst_addr_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        if (Pc_En) begin
            case (act)
                ACT_RET: begin
                    if (!Stk_Empty) begin
                        inst_addr_d = stk_top;
                        stk_pop     = 1'b1;
                    end else begin
                        inst_addr_d = seq_addr;
                        unf_d       = 1'b1;
                    end
                end
                ACT_CALL: begin
                    // The jump still happens when full; only the push is lost.
                    inst_addr_d = Pc_addr_in;
                    if (!Stk_Full) begin
                        stk_push = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                ACT_LD:  inst_addr_d = Pc_addr_in;
                ACT_BR:  inst_addr_d = br_addr;
                default: inst_addr_d = seq_addr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Pc_Rst) begin
            inst_addr_q <= RESET_ADDR;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            inst_addr_q <= inst_addr_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    program_sequencer_return_stack #(
        .DEPTH (STK_DEPTH),
        .W     (ADDR_W),
        .CNT_W (STK_CNT_W)
    ) u_return_stack (
        .clk       (clk),
        .rst       (Pc_Rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (seq_addr),
        .top       (stk_top),
        .depth     (Stk_Depth),
        .full      (Stk_Full),
        .empty     (Stk_Empty)
    );

    assign inst_addr = inst_addr_q;
    assign Stk_Ovf   = ovf_q;
    assign Stk_Unf   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        Pc_Rst = 1'b1;
    logic        Pc_En = 1'b0;
    logic        Pc_Ld = 1'b0;
    logic        Pc_Br = 1'b0;
    logic        Pc_Call = 1'b0;
    logic        Pc_Ret = 1'b0;
    logic [15:0] Pc_addr_in = 16'h0;
    logic [7:0]  Pc_Off = 8'h0;
    logic [15:0] inst_addr;
    logic [2:0]  Stk_Depth;
    logic        Stk_Full;
    logic        Stk_Empty;
    logic        Stk_Ovf;
    logic        Stk_Unf;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_stack[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        chk_on = 1'b0;

    program_sequencer dut (
        .clk        (clk),
        .Pc_Rst     (Pc_Rst),
        .Pc_En      (Pc_En),
        .Pc_Ld      (Pc_Ld),
        .Pc_Br      (Pc_Br),
        .Pc_Call    (Pc_Call),
        .Pc_Ret     (Pc_Ret),
        .Pc_addr_in (Pc_addr_in),
        .Pc_Off     (Pc_Off),
        .inst_addr  (inst_addr),
        .Stk_Depth  (Stk_Depth),
        .Stk_Full   (Stk_Full),
        .Stk_Empty  (Stk_Empty),
        .Stk_Ovf    (Stk_Ovf),
        .Stk_Unf    (Stk_Unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: stack as a queue, priority as an if-chain.
    always @(posedge clk) begin
        if (Pc_Rst) begin
            m_addr = 16'h0000;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (Pc_En) begin
            if (Pc_Ret) begin
                if (m_stack.size() > 0) begin
                    m_addr = m_stack.pop_back();
                end else begin
                    m_addr = m_addr + 16'd1;
                    m_unf = 1'b1;
                end
            end else if (Pc_Call) begin
                if (m_stack.size() < 4) m_stack.push_back(m_addr + 16'd1);
                else m_ovf = 1'b1;
                m_addr = Pc_addr_in;
            end else if (Pc_Ld) begin
                m_addr = Pc_addr_in;
            end else if (Pc_Br) begin
                m_addr = m_addr + {{8{Pc_Off[7]}}, Pc_Off};
            end else begin
                m_addr = m_addr + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("inst_addr", 32'(inst_addr), 32'(m_addr));
            check("depth", 32'(Stk_Depth), 32'(m_stack.size()));
            check("full", 32'(Stk_Full), 32'(m_stack.size() == 4));
            check("empty", 32'(Stk_Empty), 32'(m_stack.size() == 0));
            check("ovf", 32'(Stk_Ovf), 32'(m_ovf));
            check("unf", 32'(Stk_Unf), 32'(m_unf));
        end
    end

    // Drive one cycle of inputs; returns at the following negedge.
    task automatic cyc(input logic rst, input logic en, input logic ld, input logic br,
                       input logic call, input logic ret, input logic [15:0] ain,
                       input logic [7:0] off);
        Pc_Rst = rst; Pc_En = en; Pc_Ld = ld; Pc_Br = br;
        Pc_Call = call; Pc_Ret = ret; Pc_addr_in = ain; Pc_Off = off;
        @(negedge clk);
    endtask

    task automatic step();
        cyc(0, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    endtask

    task automatic load(input logic [15:0] a);
        cyc(0, 1, 1, 0, 0, 0, a, 8'h0);
    endtask

    initial begin
        // 1 reset then step
        cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
        chk_on = 1'b1;
        check("rst_addr", 32'(inst_addr), 32'h0000);
        check("rst_empty", 32'(Stk_Empty), 32'h1);
        step(); check("step1", 32'(inst_addr), 32'h0001);
        step(); check("step2", 32'(inst_addr), 32'h0002);
        step(); check("step3", 32'(inst_addr), 32'h0003);

        // 2 stall (with strobes that must be ignored) and load
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 1, 16'h1234, 8'h05);
        check("stall_hold", 32'(inst_addr), 32'h0003);
        check("stall_depth", 32'(Stk_Depth), 32'h0);
        load(16'h0F0F); check("ld", 32'(inst_addr), 32'h0F0F);
        step(); check("ld_step", 32'(inst_addr), 32'h0F10);

        // 3 branch back and wrap
        load(16'h0010);
        cyc(0, 1, 0, 1, 0, 0, 16'h0, 8'hFC); check("br_neg", 32'(inst_addr), 32'h000C);
        cyc(0, 1, 0, 1, 0, 0, 16'h0, 8'h7F); check("br_pos", 32'(inst_addr), 32'h008B);
        load(16'h0002);
        cyc(0, 1, 0, 1, 0, 0, 16'h0, 8'hFC); check("br_wrap", 32'(inst_addr), 32'hFFFE);
        load(16'hFFFF);
        step(); check("step_wrap", 32'(inst_addr), 32'h0000);

        // 4 call / return
        load(16'h0020);
        cyc(0, 1, 0, 0, 1, 0, 16'h0100, 8'h0);
        check("call", 32'(inst_addr), 32'h0100);
        check("call_depth", 32'(Stk_Depth), 32'h1);
        step(); check("call_step", 32'(inst_addr), 32'h0101);
        cyc(0, 1, 0, 0, 0, 1, 16'h0, 8'h0);
        check("ret", 32'(inst_addr), 32'h0021);
        check("ret_depth", 32'(Stk_Depth), 32'h0);
        check("ret_flags", 32'({Stk_Ovf, Stk_Unf}), 32'h0);

        // 5 overflow / underflow
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0, 16'h0200, 8'h0);
        check("ovf_full", 32'(Stk_Full), 32'h1);
        check("ovf_flag", 32'(Stk_Ovf), 32'h1);
        check("ovf_depth", 32'(Stk_Depth), 32'h4);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1, 16'h0, 8'h0);
        check("ret_bottom", 32'(inst_addr), 32'h0022);
        cyc(0, 1, 0, 0, 0, 1, 16'h0, 8'h0);
        check("unf_step", 32'(inst_addr), 32'h0023);
        check("unf_flag", 32'(Stk_Unf), 32'h1);
        step(); check("flags_sticky", 32'({Stk_Ovf, Stk_Unf}), 32'h3);

        // 6 priority and reset during call
        load(16'h0300);
        cyc(0, 1, 0, 0, 1, 0, 16'h0400, 8'h0);
        cyc(0, 1, 1, 1, 1, 1, 16'h0500, 8'h10);
        check("prio_ret", 32'(inst_addr), 32'h0301);
        check("prio_depth", 32'(Stk_Depth), 32'h0);
        cyc(0, 1, 0, 0, 1, 0, 16'h0600, 8'h0);
        cyc(1, 1, 0, 0, 1, 0, 16'h0700, 8'h0);
        check("rst_call_addr", 32'(inst_addr), 32'h0000);
        check("rst_call_depth", 32'(Stk_Depth), 32'h0);
        check("rst_call_flags", 32'({Stk_Ovf, Stk_Unf}), 32'h0);
        step(); check("post_rst", 32'(inst_addr), 32'h0001);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
